// File: rtl/sop_share_arbiter.sv
// Round-robin sharing of one pipelined SumOfProduct IP (p = a*b + c) between NUM_REQ requesters.
// Define SOP_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (rr pointer removed).
module sop_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ce,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [16*NUM_REQ-1:0]  i_a,
  input  logic [16*NUM_REQ-1:0]  i_b,
  input  logic [32*NUM_REQ-1:0]  i_c,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [NUM_REQ-1:0]     o_valid,
  output logic [31:0]            o_result,
  output logic                   o_busy,
  output logic                   o_ip_nd,
  output logic [15:0]            o_ip_a,
  output logic [15:0]            o_ip_b,
  output logic [31:0]            o_ip_c,
  input  logic [31:0]            i_ip_p
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [15:0]        a_arr [NUM_REQ];
  logic [15:0]        b_arr [NUM_REQ];
  logic [31:0]        c_arr [NUM_REQ];

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand;
  logic               issue;

  logic [NUM_REQ-1:0] grant_reg;
  logic               nd_reg;
  logic [15:0]        a_reg;
  logic [15:0]        b_reg;
  logic [31:0]        c_reg;
  logic [IW-1:0]      issue_idx_reg;

  logic [LATENCY-1:0] tag_valid_reg;
  logic [IW-1:0]      tag_idx_reg [LATENCY];

  logic [NUM_REQ-1:0] valid_reg;
  logic [31:0]        result_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = i_a[16*gi +: 16];
      assign b_arr[gi] = i_b[16*gi +: 16];
      assign c_arr[gi] = i_c[32*gi +: 32];
    end
  endgenerate

  // The requester granted on the previous edge still shows its old operands, so it is masked.
  assign eligible = i_req & ~grant_reg;
  assign issue    = ce & win_found;

`ifndef SOP_ARB_FIXED_PRIO_EN
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;

  assign ptr_next = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg <= '0;
    end else if (issue) begin
      ptr_reg <= ptr_next;
    end
  end
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SOP_ARB_FIXED_PRIO_EN
      cand = IW'(k);
`else
      cand = IW'((int'(ptr_reg) + k) % NUM_REQ);
`endif
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_reg     <= '0;
      nd_reg        <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      issue_idx_reg <= '0;
    end else begin
      nd_reg    <= issue;
      grant_reg <= issue ? (ONE_HOT0 << win_idx) : '0;
      if (issue) begin
        a_reg         <= a_arr[win_idx];
        b_reg         <= b_arr[win_idx];
        c_reg         <= c_arr[win_idx];
        issue_idx_reg <= win_idx;
      end
    end
  end

  // Tag pipe mirrors the IP latency; it runs free because the IP itself is not ce-gated.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid_reg <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_idx_reg[k] <= '0;
      end
    end else begin
      tag_valid_reg[0] <= nd_reg;
      tag_idx_reg[0]   <= issue_idx_reg;
      for (int k = 1; k < LATENCY; k++) begin
        tag_valid_reg[k] <= tag_valid_reg[k-1];
        tag_idx_reg[k]   <= tag_idx_reg[k-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg  <= '0;
      result_reg <= '0;
    end else if (tag_valid_reg[LATENCY-1]) begin
      valid_reg  <= ONE_HOT0 << tag_idx_reg[LATENCY-1];
      result_reg <= i_ip_p;
    end else begin
      valid_reg  <= '0;
    end
  end

  assign o_grant  = grant_reg;
  assign o_valid  = valid_reg;
  assign o_result = result_reg;
  assign o_busy   = nd_reg | (|tag_valid_reg);
  assign o_ip_nd  = nd_reg;
  assign o_ip_a   = a_reg;
  assign o_ip_b   = b_reg;
  assign o_ip_c   = c_reg;

endmodule
